// File: rtl/pcie_aurora_frame_pkg.sv
// Shared types and constants for the PCIe-side Aurora TX framer.
package pcie_aurora_frame_pkg;

    localparam int LEN_W = 11;

    localparam logic [31:0] START_MARK_DEF = 32'h55AA_0001;
    localparam logic [31:0] DATA_MARK_DEF  = 32'h55AA_0003;
    localparam logic [31:0] END_MARK_DEF   = 32'h55AA_0002;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ARB,
        HDR,
        PAYLOAD,
        CHK,
        END0,
        END1
    } state_t;

    // The frame counter saturates rather than wrapping so a long session never reports a small count.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pcie_aurora_frame_chk.sv
// XOR accumulator for the optional per-frame trailing check word.
// clr restarts the sum; when clr and en coincide the sum restarts at d.
module pcie_aurora_frame_chk (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] acc
);

    // Running XOR of every word accepted since the last clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= 32'h0;
        end else if (clr) begin
            acc <= en ? d : 32'h0;
        end else if (en) begin
            acc <= acc ^ d;
        end
    end

endmodule

// File: rtl/pcie_aurora_frame_tx.sv
// Aurora TX framer: START frame, fixed-length DATA frames, optional short
// flush frame, END frame carrying the DATA frame count.
// Optional build macro PCIE_AURORA_FRAME_CRC_EN appends an XOR check word
// (header ^ payload) to every DATA frame through a CHK state.
//
// state   | meaning
// IDLE    | waiting for a pending start with the channel up
// START   | presenting the single-word START frame
// ARB     | choosing full frame, flush frame, END, or wait
// HDR     | presenting the DATA frame header
// PAYLOAD | streaming FIFO words straight to the link
// CHK     | presenting the check word (CRC build only)
// END0    | presenting the END marker
// END1    | presenting the frame count, last word of the session
module pcie_aurora_frame_tx
    import pcie_aurora_frame_pkg::*;
#(
    parameter int          BURST_LEN  = 256,
    parameter logic [31:0] START_MARK = START_MARK_DEF,
    parameter logic [31:0] DATA_MARK  = DATA_MARK_DEF,
    parameter logic [31:0] END_MARK   = END_MARK_DEF
) (
    input  logic              USER_CLK,
    input  logic              RESET,
    input  logic              CHANNEL_UP,
    input  logic              adc_start,
    input  logic              adc_end,
    input  logic [LEN_W-1:0]  tx_rd_data_count,
    input  logic [31:0]       tx_rddata,
    output logic              tx_rden,
    output logic              tx_tvalid,
    output logic [31:0]       tx_data,
    output logic [3:0]        tx_tkeep,
    output logic              tx_tlast,
    input  logic              tx_tready,
    output logic              busy_o,
    output logic [15:0]       frame_cnt_o
);

    localparam logic [LEN_W-1:0] BURST_L = LEN_W'(BURST_LEN);

    state_t           state;
    logic             start_pend;
    logic             end_pend;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] wcnt;
    logic [31:0]      data_q;
    logic             tvalid_q;
    logic             tlast_q;
    logic             busy_q;
    logic [15:0]      frame_cnt_q;
    logic             xfer;

    assign xfer        = tvalid_q && tx_tready;
    // Payload words bypass the register so the FWFT head is sent without an extra cycle.
    assign tx_data     = (state == PAYLOAD) ? tx_rddata : data_q;
    assign tx_tvalid   = tvalid_q;
    assign tx_tlast    = tlast_q;
    assign tx_tkeep    = tvalid_q ? 4'hF : 4'h0;
    assign tx_rden     = (state == PAYLOAD) && tx_tready;
    assign busy_o      = busy_q;
    assign frame_cnt_o = frame_cnt_q;

`ifdef PCIE_AURORA_FRAME_CRC_EN
    localparam bit CRC_ON = 1'b1;
    logic [31:0] chk_acc;

    pcie_aurora_frame_chk u_chk (
        .clk (USER_CLK),
        .rst (RESET),
        .clr (state == HDR),
        .en  (xfer && ((state == HDR) || (state == PAYLOAD))),
        .d   (tx_data),
        .acc (chk_acc)
    );
`else
    localparam bit CRC_ON = 1'b0;
`endif

    // Session sequencing, pending-request capture and registered AXIS outputs.
    always_ff @(posedge USER_CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            start_pend  <= 1'b0;
            end_pend    <= 1'b0;
            len_q       <= '0;
            wcnt        <= '0;
            data_q      <= 32'h0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 16'h0;
        end else begin
            if (adc_start && !busy_q)
                start_pend <= 1'b1;
            // An end request is meaningful once a session is active or about to start.
            if (adc_end && (busy_q || (state != IDLE) || start_pend || adc_start))
                end_pend <= 1'b1;

            if (!CHANNEL_UP) begin
                state      <= IDLE;
                tvalid_q   <= 1'b0;
                tlast_q    <= 1'b0;
                start_pend <= 1'b0;
                end_pend   <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_pend) begin
                            state      <= START;
                            start_pend <= 1'b0;
                            tvalid_q   <= 1'b1;
                            data_q     <= START_MARK;
                            tlast_q    <= 1'b1;
                        end
                    end
                    START: begin
                        if (xfer) begin
                            state       <= ARB;
                            busy_q      <= 1'b1;
                            frame_cnt_q <= 16'h0;
                            tvalid_q    <= 1'b0;
                            tlast_q     <= 1'b0;
                        end
                    end
                    ARB: begin
                        if (tx_rd_data_count >= BURST_L) begin
                            state    <= HDR;
                            len_q    <= BURST_L;
                            tvalid_q <= 1'b1;
                            data_q   <= DATA_MARK;
                            tlast_q  <= 1'b0;
                        end else if (end_pend && (tx_rd_data_count != '0)) begin
                            state    <= HDR;
                            len_q    <= tx_rd_data_count;
                            tvalid_q <= 1'b1;
                            data_q   <= DATA_MARK;
                            tlast_q  <= 1'b0;
                        end else if (end_pend) begin
                            state    <= END0;
                            tvalid_q <= 1'b1;
                            data_q   <= END_MARK;
                            tlast_q  <= 1'b0;
                        end
                    end
                    HDR: begin
                        if (xfer) begin
                            state   <= PAYLOAD;
                            wcnt    <= len_q;
                            tlast_q <= (len_q == 11'd1) && !CRC_ON;
                        end
                    end
                    PAYLOAD: begin
                        if (xfer) begin
                            if (wcnt == 11'd1) begin
                                frame_cnt_q <= sat_inc16(frame_cnt_q);
`ifdef PCIE_AURORA_FRAME_CRC_EN
                                state   <= CHK;
                                data_q  <= chk_acc ^ tx_rddata;
                                tlast_q <= 1'b1;
`else
                                state    <= ARB;
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
`endif
                            end else begin
                                wcnt    <= wcnt - 11'd1;
                                tlast_q <= (wcnt == 11'd2) && !CRC_ON;
                            end
                        end
                    end
`ifdef PCIE_AURORA_FRAME_CRC_EN
                    CHK: begin
                        if (xfer) begin
                            state    <= ARB;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                        end
                    end
`endif
                    END0: begin
                        if (xfer) begin
                            state   <= END1;
                            data_q  <= {16'h0, frame_cnt_q};
                            tlast_q <= 1'b1;
                        end
                    end
                    END1: begin
                        if (xfer) begin
                            state    <= IDLE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            end_pend <= 1'b0;
                            busy_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
